// File: rtl/operand_entry_pkg.sv
// Shared types and sizing for the two-operand entry block.
package operand_entry_pkg;
  localparam int OP_W            = 3;
  localparam int CNT_W           = 5;
  localparam int DEB_CYCLES_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    SHOW  = 2'd2
  } state_e;
endpackage

// File: rtl/btn_debounce.sv
// Synchronizes a bouncy button, debounces it with a run-length counter and
// emits a one-cycle pulse on each debounced rising edge.
module btn_debounce
  import operand_entry_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   press_q, press_d;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Counter tracks how long the synced input has disagreed with the level.
  always_comb begin
    cnt_d   = '0;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    if (btn_s != lvl_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        lvl_d   = ~lvl_q;
        press_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q[0] <= btn_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
    end
  end

  assign level_o = lvl_q;
  assign press_o = press_q;
endmodule

// File: rtl/operand_entry_fsm.sv
// Button-driven entry of two 3-bit operands from switches; outputs are all
// registered and packed onto an 8-bit pin bus.
module operand_entry_fsm
  import operand_entry_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  logic clk, rst_n, press, btn_level;
  logic unused_in;

  assign clk       = io_in[0];
  assign rst_n     = io_in[1];
  assign unused_in = ^{io_in[7], btn_level};

  // clr and sw share one synchronizer chain: {clr, sw}.
  logic [SYNC_STAGES-1:0][OP_W:0] sync_q;
  logic                           clr_s;
  logic [OP_W-1:0]                sw_s;

  assign {clr_s, sw_s} = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {io_in[3], io_in[6:4]};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .btn_i  (io_in[2]),
    .level_o(btn_level),
    .press_o(press)
  );

  state_e          state_q;
  logic [OP_W-1:0] op_a_q, op_b_q;
  logic            valid_q, want_b_q;

  // clr is checked first so it always beats a coincident press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= GET_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      valid_q  <= 1'b0;
      want_b_q <= 1'b0;
    end else if (clr_s) begin
      state_q  <= GET_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      valid_q  <= 1'b0;
      want_b_q <= 1'b0;
    end else if (press) begin
      case (state_q)
        GET_A: begin
          op_a_q   <= sw_s;
          state_q  <= GET_B;
          want_b_q <= 1'b1;
        end
        GET_B: begin
          op_b_q   <= sw_s;
          valid_q  <= 1'b1;
          state_q  <= SHOW;
          want_b_q <= 1'b0;
        end
        SHOW: begin
          op_a_q   <= sw_s;
          valid_q  <= 1'b0;
          state_q  <= GET_B;
          want_b_q <= 1'b1;
        end
        default: begin
          state_q  <= GET_A;
          want_b_q <= 1'b0;
        end
      endcase
    end
  end

  assign io_out = {want_b_q, valid_q, op_b_q, op_a_q};
endmodule

// File: tb/tb_operand_entry_fsm.sv
// Randomized and directed bench for operand_entry_fsm against a run-length
// debounce model and a phase-counter entry model.
module tb_operand_entry_fsm;
  localparam int DEB = 16;
  localparam int S   = 2;

  logic       clk = 1'b0;
  logic       rst_n_r = 1'b0;
  logic       btn_r = 1'b0, clr_r = 1'b0, unused_r = 1'b0;
  logic [2:0] sw_r = 3'd0;
  logic [7:0] io_in, io_out;

  int n_checks = 0;
  int n_errors = 0;

  assign io_in = {unused_r, sw_r, clr_r, btn_r, rst_n_r, clk};

  operand_entry_fsm #(.DEB_CYCLES(DEB), .SYNC_STAGES(S)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  // Reference model: inputs reach the logic S edges late; the level flips
  // once the synced input has disagreed with it for DEB consecutive edges.
  bit       bh [S];
  bit       ch [S];
  bit [2:0] swh[S];
  bit       m_lvl = 0, m_press = 0, m_v = 0;
  int       m_run = 0, m_phase = 0;  // 0: want A, 1: want B, 2: showing
  bit [2:0] m_a = 0, m_b = 0;

  function automatic bit [7:0] exp_out();
    return {m_phase == 1, m_v, m_b, m_a};
  endfunction

  always @(posedge clk or negedge rst_n_r) begin
    if (!rst_n_r) begin
      for (int i = 0; i < S; i++) begin bh[i] = 0; ch[i] = 0; swh[i] = 0; end
      m_lvl = 0; m_press = 0; m_v = 0; m_run = 0; m_phase = 0; m_a = 0; m_b = 0;
    end else begin
      if (ch[S-1]) begin
        m_a = 0; m_b = 0; m_v = 0; m_phase = 0;
      end else if (m_press) begin
        if (m_phase == 1) begin m_b = swh[S-1]; m_v = 1; m_phase = 2; end
        else begin m_a = swh[S-1]; m_v = 0; m_phase = 1; end
      end
      m_press = 0;
      if (bh[S-1] != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin m_lvl = !m_lvl; m_run = 0; m_press = m_lvl; end
      end else begin
        m_run = 0;
      end
      for (int i = S - 1; i > 0; i--) begin bh[i] = bh[i-1]; ch[i] = ch[i-1]; swh[i] = swh[i-1]; end
      bh[0] = btn_r; ch[0] = clr_r; swh[0] = sw_r;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      unused_r = 1'($urandom);
    end
  endtask

  task automatic press(input bit [2:0] v, input int hi, input int lo);
    sw_r = v; btn_r = 1; tick(hi);
    btn_r = 0; tick(lo);
  endtask

  task automatic test_reset();
    rst_n_r = 0; tick(3);
    n_checks++;
    if (io_out !== 8'h00) begin n_errors++; $display("FAIL reset_held: io_out=%h expected 00", io_out); end
    rst_n_r = 1; tick(3);
    n_checks++;
    if (io_out !== exp_out() || io_out !== 8'h00) begin
      n_errors++; $display("FAIL reset_release: io_out=%h expected 00", io_out);
    end
  endtask

  task automatic test_load_a();
    press(3'd5, 20, 22);
    n_checks++;
    if (io_out !== 8'h85 || io_out !== exp_out()) begin
      n_errors++; $display("FAIL load_a: io_out=%h expected 85 (model %h)", io_out, exp_out());
    end
  endtask

  task automatic test_load_b();
    logic [3:0] sum;
    press(3'd3, 20, 22);
    n_checks++;
    if (io_out !== 8'h5D || io_out !== exp_out()) begin
      n_errors++; $display("FAIL load_b: io_out=%h expected 5d (model %h)", io_out, exp_out());
    end
    sum = {1'b0, io_out[2:0]} + {1'b0, io_out[5:3]};
    n_checks++;
    if (sum !== 4'd8) begin n_errors++; $display("FAIL adder_sum: got %0d expected 8", sum); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin btn_r = ~btn_r; tick(3); end
    btn_r = 0; tick(25);
    n_checks++;
    if (io_out !== 8'h5D || io_out !== exp_out()) begin
      n_errors++; $display("FAIL bounce_no_press: io_out=%h expected 5d", io_out);
    end
  endtask

  task automatic test_show_press();
    press(3'd7, 20, 22);
    n_checks++;
    if (io_out !== 8'h9F || io_out !== exp_out()) begin
      n_errors++; $display("FAIL show_press: io_out=%h expected 9f", io_out);
    end
  endtask

  task automatic test_clr_press();
    sw_r = 3'd6; btn_r = 1; tick(16);
    clr_r = 1; tick(1);
    clr_r = 0; tick(25);
    n_checks++;
    if (io_out !== 8'h00 || io_out !== exp_out()) begin
      n_errors++; $display("FAIL clr_vs_press: io_out=%h expected 00", io_out);
    end
    btn_r = 0; tick(25);
    press(3'd2, 20, 22);
    n_checks++;
    if (io_out !== 8'h82 || io_out !== exp_out()) begin
      n_errors++; $display("FAIL after_clr_load_a: io_out=%h expected 82", io_out);
    end
  endtask

  task automatic test_clr_hold();
    clr_r = 1; tick(4);
    press(3'd6, 20, 22);
    n_checks++;
    if (io_out !== 8'h00 || io_out !== exp_out()) begin
      n_errors++; $display("FAIL clr_hold: io_out=%h expected 00", io_out);
    end
    clr_r = 0; tick(4);
    press(3'd4, 20, 22);
    n_checks++;
    if (io_out !== 8'h84 || io_out !== exp_out()) begin
      n_errors++; $display("FAIL clr_release_load: io_out=%h expected 84", io_out);
    end
  endtask

  task automatic test_reset_mid();
    sw_r = 3'd5; btn_r = 1; tick(12);
    rst_n_r = 0; #1;
    n_checks++;
    if (io_out !== 8'h00) begin n_errors++; $display("FAIL async_reset: io_out=%h expected 00", io_out); end
    @(negedge clk);
    btn_r = 0; rst_n_r = 1; tick(5);
    press(3'd1, 20, 22);
    n_checks++;
    if (io_out !== 8'h81 || io_out !== exp_out()) begin
      n_errors++; $display("FAIL reset_then_load_a: io_out=%h expected 81", io_out);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    int shown = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        btn_r = ~btn_r;
        hold  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 40);
        if (btn_r) sw_r = 3'($urandom);
      end
      hold--;
      clr_r = ($urandom_range(0, 99) < 2);
      tick(1);
      n_checks++;
      if (io_out !== exp_out()) begin
        n_errors++;
        if (shown < 10) begin
          shown++; $display("FAIL random cyc %0d: io_out=%h expected %h", c, io_out, exp_out());
        end
      end
    end
    btn_r = 0; clr_r = 0; tick(25);
  endtask

  initial begin
    tick(1);
    test_reset();
    test_load_a();
    test_load_b();
    test_bounce();
    test_show_press();
    test_clr_press();
    test_clr_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
